// File: rtl/gf180mcu_fd_sc_mcu9t5v0__latbank_wr_ctrl_pkg.sv
// Shared definitions for the latch-bank write controller.
//   wr_state_e : write-sequence FSM states
//   DEF_WIDTH  : default latch word width
//   DEF_AW     : default latch address width
package gf180mcu_fd_sc_mcu9t5v0__latbank_wr_ctrl_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_AW    = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ENABLE = 2'd2,
    HOLD   = 2'd3
  } wr_state_e;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__latbank_rr_arb2.sv
// Two-way round-robin arbiter (purely combinational).
//   req_i [1:0] : request vector
//   ptr_i       : index of the requester granted last
//   upd_i       : arbitration strobe; grant is forced to zero when low
//   gnt_o [1:0] : one-hot grant
module gf180mcu_fd_sc_mcu9t5v0__latbank_rr_arb2
  import gf180mcu_fd_sc_mcu9t5v0__latbank_wr_ctrl_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  input  logic       upd_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (upd_i) begin
      if (req_i == 2'b11) begin
        // Under contention the requester not granted last wins.
        gnt_o = ptr_i ? 2'b01 : 2'b10;
      end else begin
        gnt_o = req_i;
      end
    end
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__latbank_wr_ctrl.sv
// Write controller for a bank of 2**AW level-sensitive latch words.
// Arbitrates two requesters, then sequences setup / enable / hold so the
// shared data bus is stable around the single-cycle latch enable pulse.
//   CLK, RST           : clock, synchronous active-high reset
//   REQ0/1             : write requests
//   ADDR0/1, DATA0/1   : target word and write data per requester
//   GNT0/1             : one-cycle write-complete acknowledge
//   E [DEPTH-1:0]      : one-hot latch enables (registered)
//   D [WIDTH-1:0]      : shared latch data bus (registered)
//   BUSY               : high when a write is in progress
//
// state  | meaning
// IDLE   | waiting; arbitration and capture of winner's addr/data
// SETUP  | data driven onto D, enables low
// ENABLE | enable of captured word high
// HOLD   | enables low, data held, winner's GNT high
module gf180mcu_fd_sc_mcu9t5v0__latbank_wr_ctrl
  import gf180mcu_fd_sc_mcu9t5v0__latbank_wr_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = DEF_AW
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 REQ0,
  input  logic                 REQ1,
  input  logic [AW-1:0]        ADDR0,
  input  logic [AW-1:0]        ADDR1,
  input  logic [WIDTH-1:0]     DATA0,
  input  logic [WIDTH-1:0]     DATA1,
  output logic                 GNT0,
  output logic                 GNT1,
  output logic [(1<<AW)-1:0]   E,
  output logic [WIDTH-1:0]     D,
  output logic                 BUSY
);

  localparam int DEPTH = 1 << AW;

  wr_state_e        state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [DEPTH-1:0] e_q, e_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             win_q, win_d;
  logic             ptr_q, ptr_d;
  logic [1:0]       arb_gnt;

  gf180mcu_fd_sc_mcu9t5v0__latbank_rr_arb2 u_arb (
    .req_i (({REQ1, REQ0})),
    .ptr_i (ptr_q),
    .upd_i (state_q == IDLE),
    .gnt_o (arb_gnt)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
    e_d     = '0;
    gnt_d   = 2'b00;
    case (state_q)
      IDLE: begin
        if (arb_gnt != 2'b00) begin
          state_d = SETUP;
          win_d   = arb_gnt[1];
          ptr_d   = arb_gnt[1];
          addr_d  = arb_gnt[1] ? ADDR1 : ADDR0;
          data_d  = arb_gnt[1] ? DATA1 : DATA0;
        end
      end
      SETUP: begin
        state_d      = ENABLE;
        // Decode ahead of the flop so E itself comes straight from registers.
        e_d[addr_q]  = 1'b1;
      end
      ENABLE: begin
        state_d      = HOLD;
        gnt_d[win_q] = 1'b1;
      end
      HOLD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      e_q     <= '0;
      gnt_q   <= 2'b00;
      win_q   <= 1'b0;
      ptr_q   <= 1'b1;   // requester 0 wins the first contention
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      e_q     <= e_d;
      gnt_q   <= gnt_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
    end
  end

  assign E    = e_q;
  assign D    = data_q;
  assign GNT0 = gnt_q[0];
  assign GNT1 = gnt_q[1];
  assign BUSY = (state_q != IDLE);

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__latbank_wr_ctrl.sv
// Scoreboard bench: the driver models arbitration at transaction level and
// queues expected writes; the monitor checks each GNT against the queue and
// checks bus/enable invariants every cycle.
module tb_gf180mcu_fd_sc_mcu9t5v0__latbank_wr_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       REQ0 = 1'b0, REQ1 = 1'b0;
  logic [2:0] ADDR0 = '0, ADDR1 = '0;
  logic [7:0] DATA0 = '0, DATA1 = '0;
  logic       GNT0, GNT1, BUSY;
  logic [7:0] E, D;

  gf180mcu_fd_sc_mcu9t5v0__latbank_wr_ctrl dut (
    .CLK(CLK), .RST(RST), .REQ0(REQ0), .REQ1(REQ1),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .DATA0(DATA0), .DATA1(DATA1),
    .GNT0(GNT0), .GNT1(GNT1), .E(E), .D(D), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit         who;
    logic [2:0] addr;
    logic [7:0] data;
    time        t;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         fails  = 0;
  logic [7:0] mem [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver + transaction-level reference model
  localparam int NCYC = 3000;

  initial begin
    bit         pend [2];
    logic [2:0] raddr [2];
    logic [7:0] rdata [2];
    int         phase;
    bit         ptr, win, rst_now, dir_done;
    int         prob [2];
    exp_t       e;
    pend[0] = 0; pend[1] = 0;
    raddr[0] = '0; raddr[1] = '0; rdata[0] = '0; rdata[1] = '0;
    phase = 0; ptr = 1'b1; win = 1'b0; dir_done = 0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge CLK);
      if (cyc < 400)           begin prob[0] = 100; prob[1] = 100; end
      else if (cyc < 800)      begin prob[0] = 0;   prob[1] = 100; end
      else if (cyc < NCYC-50)  begin prob[0] = 30;  prob[1] = 30;  end
      else                     begin prob[0] = 0;   prob[1] = 0;   end
      rst_now = (cyc < 3);
      if (cyc >= 800 && cyc < NCYC-50 && $urandom_range(49) == 0) rst_now = 1;
      if (cyc >= 820 && !dir_done && phase == 2) begin rst_now = 1; dir_done = 1; end
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(99) < prob[r]) begin
          pend[r]  = 1;
          raddr[r] = 3'($urandom);
          rdata[r] = 8'($urandom);
        end
      end
      RST = rst_now;
      REQ0 = pend[0]; ADDR0 = raddr[0]; DATA0 = rdata[0];
      REQ1 = pend[1]; ADDR1 = raddr[1]; DATA1 = rdata[1];
      // Disturb the in-flight requester's inputs after capture.
      if (cyc >= 800 && (phase == 1 || phase == 2) && $urandom_range(1) == 1) begin
        if (win) begin ADDR1 = 3'($urandom); DATA1 = 8'($urandom); end
        else     begin ADDR0 = 3'($urandom); DATA0 = 8'($urandom); end
      end
      @(posedge CLK);
      if (rst_now) begin
        if (phase == 1 || phase == 2) void'(sb.pop_back());
        phase = 0;
        ptr   = 1'b1;
      end else if (phase == 0) begin
        if (pend[0] || pend[1]) begin
          win   = (pend[0] && pend[1]) ? ~ptr : pend[1];
          ptr   = win;
          e.who = win; e.addr = raddr[win]; e.data = rdata[win]; e.t = $time;
          sb.push_back(e);
          phase = 1;
        end
      end else begin
        phase = (phase + 1) % 4;
        if (phase == 3) pend[win] = 0;
      end
    end
    repeat (4) @(negedge CLK);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Monitor
  initial begin
    logic [7:0] pe, pd, laste;
    logic       pb;
    exp_t       x;
    pe = '0; pd = '0; pb = 1'b0; laste = '0;
    forever begin
      @(posedge CLK); #1;
      chk("e_onehot", 64'($countones(E) <= 1), 64'd1);
      chk("gnt_excl", 64'(GNT0 & GNT1), 64'd0);
      if (RST) begin
        chk("rst_E", 64'(E), 64'd0);
        chk("rst_gnt", 64'({GNT1, GNT0}), 64'd0);
        chk("rst_busy", 64'(BUSY), 64'd0);
        chk("rst_D", 64'(D), 64'd0);
      end else begin
        if (pe != 0) chk("e_consec", 64'(E), 64'd0);
        if (!(pb == 1'b0 && BUSY == 1'b1)) chk("d_stable", 64'(D), 64'(pd));
      end
      for (int i = 0; i < 8; i++) if (E[i]) mem[i] = D;
      if (E != 0) laste = E;
      if (GNT0 || GNT1) begin
        if (sb.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_gnt: got gnt=%b expected none at %0t", {GNT1, GNT0}, $time);
        end else begin
          x = sb.pop_front();
          chk("gnt_who", 64'(GNT1), 64'(x.who));
          chk("gnt_time", 64'($time), 64'(x.t + 21));
          chk("gnt_D", 64'(D), 64'(x.data));
          chk("latch_word", 64'(mem[x.addr]), 64'(x.data));
          chk("e_addr", 64'(laste), 64'(8'd1 << x.addr));
          chk("gnt_busy", 64'(BUSY), 64'd1);
        end
      end
      pe = E; pd = D; pb = BUSY;
    end
  end

endmodule
